platform_host_sequencer: RTL

Synthesizable host-side sequencer for the virtual platform. It streams a program image from a synchronous image memory into the platform's program ROM. It then pulses the platform reset and services the platform's operand requests (din_req/din_rdy) from an operand FIFO. It captures the platform's results (dout/dout_rdy) until a configured result count or a timeout is reached. It sits between a host/stimulus source and the top-level platform, replacing hand-sequenced load/run stimulus with a reusable, parametrised engine.

---
 rtl/platform_host_sequencer.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/platform_host_sequencer.sv
// Host-side load/run sequencer: streams an image into the platform ROM, pulses platform reset, then feeds operands and captures results.
// Latency: first ROM write 1 cycle after LOAD entry; din_req->din_rdy 1 cycle; dout_rdy rise->res_valid 1 cycle; last capture->done 1 cycle.
// Backpressure: op_ready drops when the operand FIFO is full or in reset; din_req with an empty FIFO simply waits.
//
// Ports:
//   clk, rst            single clock, synchronous active-low reset
//   start               begin load/run (accepted only in IDLE/DONE)
//   img_addr/img_data   synchronous image-memory read port (data one cycle after address)
//   sw_addr/sw_din/we_n platform program-ROM write port; mode=1 while loading
//   prst                platform reset pulse
//   op_data/op_valid/op_ready  operand enqueue
//   din/din_rdy/din_req 4-phase operand handshake to the platform
//   dout/dout_rdy       platform result, captured on the rising edge of dout_rdy
//   res_data/res_valid  captured result, one-cycle pulse
//   busy/done/timeout   sequence status

module platform_host_sequencer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat
);
    // Generic single-clock FIFO, no bypass.
    // Latency: a pushed word is visible at the head on the next cycle.
    // Backpressure: push_rdy low when full or held in reset; push and pop may coincide.

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_rdy = rst && !full;
    assign pop_vld  = !empty;
    assign pop_dat  = mem[rd_ptr[PTR_W-1:0]];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && !empty;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_dat;
        end
    end

endmodule

module platform_host_sequencer #(
    parameter int ADDR_W      = 14,
    parameter int ROM_DEPTH   = 16384,
    parameter int BYTE_W      = 8,
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRST_CYCLES = 1,
    parameter int N_RES       = 1,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [BYTE_W-1:0] img_data,
    output logic [ADDR_W-1:0] sw_addr,
    output logic [BYTE_W-1:0] sw_din,
    output logic              we_n,
    output logic              mode,
    output logic              prst,
    input  logic [DATA_W-1:0] op_data,
    input  logic              op_valid,
    output logic              op_ready,
    output logic [DATA_W-1:0] din,
    output logic              din_rdy,
    input  logic              din_req,
    input  logic [DATA_W-1:0] dout,
    input  logic              dout_rdy,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRST,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
    localparam logic [31:0]       PRST_LAST = 32'(PRST_CYCLES - 1);
    localparam logic [31:0]       RES_LAST  = 32'(N_RES - 1);
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);
    localparam bit                TMO_EN    = (TIMEOUT != 0);

    state_t            state;
    logic [31:0]       prst_cnt;
    logic [31:0]       res_cnt;
    logic [31:0]       tmo_cnt;
    logic              dout_rdy_q;

    logic              start_acc;
    logic              fifo_vld;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_pop;
    logic              capture;

    assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
    assign fifo_pop  = (state == S_RUN) && din_req && !din_rdy && fifo_vld;
    assign capture   = (state == S_RUN) && dout_rdy && !dout_rdy_q;

    // The image memory returns data one cycle after the address, which is
    // exactly the cycle the write is presented, so the data passes straight
    // through while a write is active and reads as zero otherwise.
    assign sw_din = we_n ? '0 : img_data;

    platform_host_sequencer_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_op_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_acc),
        .push_vld (op_valid),
        .push_rdy (op_ready),
        .push_dat (op_data),
        .pop_rdy  (fifo_pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (fifo_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            img_addr   <= '0;
            sw_addr    <= '0;
            we_n       <= 1'b1;
            mode       <= 1'b0;
            prst       <= 1'b0;
            din        <= '0;
            din_rdy    <= 1'b0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            prst_cnt   <= '0;
            res_cnt    <= '0;
            tmo_cnt    <= '0;
            dout_rdy_q <= 1'b0;
        end else begin
            res_valid  <= 1'b0;
            dout_rdy_q <= dout_rdy;

            // Return-to-zero half of the operand handshake.
            if (din_rdy && !din_req) begin
                din_rdy <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        img_addr <= '0;
                        we_n     <= 1'b1;
                        mode     <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        res_cnt  <= '0;
                        din_rdy  <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (!we_n && (sw_addr == LAST_ADDR)) begin
                        // The last word is being written this cycle.
                        state    <= S_PRST;
                        we_n     <= 1'b1;
                        mode     <= 1'b0;
                        prst     <= 1'b1;
                        prst_cnt <= '0;
                    end else begin
                        // Write follows the read address by one cycle; the
                        // read address parks on the last word instead of wrapping.
                        sw_addr <= img_addr;
                        we_n    <= 1'b0;
                        if (img_addr != LAST_ADDR) begin
                            img_addr <= img_addr + 1'b1;
                        end
                    end
                end

                S_PRST: begin
                    if (prst_cnt == PRST_LAST) begin
                        state   <= S_RUN;
                        prst    <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        prst_cnt <= prst_cnt + 32'd1;
                    end
                end

                S_RUN: begin
                    if (fifo_pop) begin
                        din     <= fifo_dat;
                        din_rdy <= 1'b1;
                    end
                    if (capture) begin
                        res_data  <= dout;
                        res_valid <= 1'b1;
                        res_cnt   <= res_cnt + 32'd1;
                    end

                    if (capture && (res_cnt == RES_LAST)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (fifo_pop || capture) begin
                        tmo_cnt <= '0;
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
